// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA/STATUS words beside RAM, small byte FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1) and report it in STATUS[8].
module uart_tx_mmio #(
    parameter logic [29:0] BASE         = 30'h3FFFFFF0,
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        hit_q,
    output logic        tx,
    output logic        busy
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]      BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wptr_q, rptr_q;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 full, empty, wr_hit, st_hit, rd_hit, push, pop;
    logic [31:0]          status;
    logic                 unused_wdata;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign unused_wdata = ^wdata[31:8];

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign busy   = (state_q != IDLE) | ~empty;
    assign wr_hit = we & (addr == BASE);
    assign st_hit = re & (addr == BASE + 30'd1);
    assign rd_hit = st_hit | (re & (addr == BASE));
    assign push   = wr_hit & ~full;

    // Status is built from pre-edge registered values only.
    assign status  = {23'd0, PAR_EN, 4'(count_q), ovf_q, busy, empty, full};
    assign rdata_d = st_hit ? status : 32'd0;
    assign rdata   = rdata_q;

    // A drop on a full FIFO outranks the clear-on-read.
    always_comb begin
        ovf_d = ovf_q;
        if (st_hit)         ovf_d = 1'b0;
        if (wr_hit && full) ovf_d = 1'b1;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx      = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
                    par_d   = ^mem_q[rptr_q];
`endif
                    baud_d  = BAUD_MAX;
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_q == '0) begin
                    baud_d  = BAUD_MAX;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (baud_q == '0) begin
                    baud_d  = BAUD_MAX;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = par_q;
                if (baud_q == '0) begin
                    baud_d  = BAUD_MAX;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_q == '0) state_d = IDLE;
                else              baud_d  = baud_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            hit_q   <= rd_hit;
            rdata_q <= rdata_d;
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata[7:0];
    end
endmodule
